fbr_arbiter: RTL and testbench
==============================

Name: fbr_arbiter

Overview:
- Shares one `fbranch` FP comparator between two requesters.
  - Port 0: the branch unit, for FBEQ/FBNE/FBLT/FBGE resolution.
  - Port 1: the FP compare-to-register path.
- Arbitrates requests with valid/ready handshakes and registers the winning operands.
- Presents the comparator result one cycle later on a single valid/ready output channel, together with source ID and tag.
- Sits between issue/dispatch and the branch-redirect / FP writeback logic.

Parameters:
- TAG_W, 5: width of the opaque requester tag returned with each result.
- FIXED_PRIO, 0: 0 = round-robin arbitration; 1 = port 0 always wins.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; kills the held result and blocks acceptance this cycle.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 accepted this cycle (combinational).
- req0_func3  in  `LEN_FUNC3  comparison select (`FUNC3_FBEQ/FBNE/FBLT, other = GE).
- req0_rs1, req0_rs2  in  `LEN_WORD  IEEE-754 single operands.
- req0_tag  in  TAG_W  requester tag.
- req1_valid, req1_ready, req1_func3, req1_rs1, req1_rs2, req1_tag: same as port 0, for port 1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_jump  out  1  comparator result for the held request.
- out_src  out  1  0 = port 0, 1 = port 1.
- out_tag  out  TAG_W  tag of the held request.

Behaviour:
- Reset (async, rstn=0) clears:
  - out_valid=0, out_src=0, out_tag=0;
  - held func3/rs1/rs2 = 0;
  - RR pointer = 0 (port 0 preferred).
- Reset release is synchronous to clk.
- State machine, one result slot:
  - EMPTY: out_valid=0. FULL: out_valid=1.
  - space = EMPTY, or (FULL and out_ready).
  - grant possible iff space && !flush && (req0_valid || req1_valid).
- Grant selection:
  - FIXED_PRIO=1: port 0 whenever req0_valid.
  - FIXED_PRIO=0: if both valid, the port equal to the RR pointer wins; if one valid, that port wins.
  - RR pointer <= ~granted port, updated only on a grant.
- reqN_ready = grant && (winner==N). Ready is never asserted for the loser or for an invalid port.
- On grant, at clk edge:
  - capture func3, rs1, rs2, tag, src into the holding register;
  - state -> FULL.
- Latency:
  - Request accepted at edge N gives out_valid=1 after edge N.
  - out_jump is combinational from the holding register through `fbranch`, so it is stable for the whole FULL period.
- Drain: FULL && out_ready && no grant -> EMPTY.
- Back-to-back: FULL && out_ready && grant -> FULL with the new contents. This sustains one result per cycle.
- Stall: FULL && !out_ready holds all outputs unchanged. Both readies are 0 and requesters must hold their requests.
- Flush:
  - FULL or EMPTY -> EMPTY next edge.
  - No grant that cycle; RR pointer unchanged.
  - Flush has priority over out_ready; a result presented in the flush cycle may be taken by the consumer only if it also samples out_ready=1, and the slot clears anyway.
- Comparator semantics inherited unchanged:
  - +0 equals -0; -0 is not less than +0.
  - Any NaN makes LT false, so GE is true and FBNE is true unless the bit patterns are equal.
- Reset mid-operation: the held result is discarded immediately (out_valid drops asynchronously); no partial state survives.
- Widths: pointer 1 bit; no arithmetic beyond the comparator; operands are passed unmodified.

Test Plan:
- Single port 0 request: func3=FBEQ, rs1=32'h00000000, rs2=32'h80000000, tag=3.
  - Required: req0_ready=1 that cycle; next cycle out_valid=1, out_jump=1, out_src=0, out_tag=3.
- NaN handling on port 1: rs1=32'h7FC00000, rs2=32'h3F800000.
  - FBLT: out_jump=0.
  - GE (func3 not EQ/NE/LT): out_jump=1.
  - FBNE: out_jump=1.
- Round-robin, FIXED_PRIO=0, out_ready=1, both ports valid for 4 cycles.
  - Required grant order 0,1,0,1; out_src follows one cycle later; one result per cycle, no bubbles.
- Backpressure: hold out_ready=0 for 3 cycles with result rs1=32'hBF800000 < rs2=32'h3F800000, FBLT.
  - Required: out_jump=1 held stable; both readies 0.
  - out_ready=1 then drains the result, and the pending request is granted in the same cycle.
- Flush: assert flush while FULL with both ports valid.
  - Required: no ready asserted; out_valid=0 next cycle; RR pointer unchanged, so the same port wins on the next grant.
- Async reset: drop rstn mid-cycle while FULL.
  - Required: out_valid=0 immediately, out_tag=0.
  - After release, a first request with both ports valid grants port 0.

Source files
------------

// File: rtl/fbr_arbiter_if.sv
// Request/response bundle for the shared FP branch comparator: two requester
// channels plus the single result channel.
interface fbr_arbiter_if #(
  parameter int TAG_W = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_func3;
  logic [31:0]      req0_rs1;
  logic [31:0]      req0_rs2;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_func3;
  logic [31:0]      req1_rs1;
  logic [31:0]      req1_rs2;
  logic [TAG_W-1:0] req1_tag;

  logic             out_valid;
  logic             out_ready;
  logic             out_jump;
  logic             out_src;
  logic [TAG_W-1:0] out_tag;

  // Requesters and result consumer.
  modport master (
    output req0_valid, req0_func3, req0_rs1, req0_rs2, req0_tag,
    input  req0_ready,
    output req1_valid, req1_func3, req1_rs1, req1_rs2, req1_tag,
    input  req1_ready,
    input  out_valid, out_jump, out_src, out_tag,
    output out_ready
  );

  // Arbiter.
  modport slave (
    input  req0_valid, req0_func3, req0_rs1, req0_rs2, req0_tag,
    output req0_ready,
    input  req1_valid, req1_func3, req1_rs1, req1_rs2, req1_tag,
    output req1_ready,
    output out_valid, out_jump, out_src, out_tag,
    input  out_ready
  );
endinterface

// File: rtl/fbr_arbiter.sv
// Two-port arbiter in front of one FP branch comparator, with a single-entry
// result slot that sustains one result per cycle.
module fbranch (
  input  logic [2:0]  func3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        jump
);
  localparam logic [2:0] FUNC3_FBEQ = 3'b000;
  localparam logic [2:0] FUNC3_FBNE = 3'b001;
  localparam logic [2:0] FUNC3_FBLT = 3'b100;

  logic nan1, nan2, zero2x, eq, lt;

  assign nan1   = (rs1[30:23] == 8'hff) && (rs1[22:0] != 23'd0);
  assign nan2   = (rs2[30:23] == 8'hff) && (rs2[22:0] != 23'd0);
  assign zero2x = (rs1[30:0] == 31'd0) && (rs2[30:0] == 31'd0);
  // NaN equality is bitwise on purpose; only the signed-zero pair is special.
  assign eq     = (rs1 == rs2) || zero2x;

  always_comb begin
    lt = 1'b0;
    if (nan1 || nan2 || zero2x)   lt = 1'b0;
    else if (rs1[31] != rs2[31])  lt = rs1[31];
    else if (!rs1[31])            lt = rs1[30:0] < rs2[30:0];
    else                          lt = rs1[30:0] > rs2[30:0];
  end

  always_comb begin
    case (func3)
      FUNC3_FBEQ: jump = eq;
      FUNC3_FBNE: jump = !eq;
      FUNC3_FBLT: jump = lt;
      default:    jump = !lt;
    endcase
  end
endmodule

module fbr_arbiter #(
  parameter int TAG_W      = 5,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  fbr_arbiter_if.slave bus
);
  typedef struct packed {
    logic [2:0]       func3;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] vld, rdy;
  logic       space, grant, win, rr_q, src_q;
  req_t       req [2];
  req_t       hold_q;

  assign vld    = {bus.req1_valid, bus.req0_valid};
  assign req[0] = '{func3: bus.req0_func3, rs1: bus.req0_rs1, rs2: bus.req0_rs2, tag: bus.req0_tag};
  assign req[1] = '{func3: bus.req1_func3, rs1: bus.req1_rs1, rs2: bus.req1_rs2, tag: bus.req1_tag};

  always_comb begin
    state_d = state_q;
    space   = (state_q == EMPTY) || bus.out_ready;
    grant   = space && !flush && (|vld);
    win     = 1'b0;
    rdy     = 2'b00;
    if (FIXED_PRIO) win = !vld[0];
    else            win = (&vld) ? rr_q : vld[1];
    if (grant) rdy = win ? 2'b10 : 2'b01;
    // Flush wins over both a new grant and a drain.
    if (flush)                                  state_d = EMPTY;
    else if (grant)                             state_d = FULL;
    else if (state_q == FULL && bus.out_ready)  state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) rr_q <= ~win;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q <= '0;
      src_q  <= 1'b0;
    end else if (grant) begin
      hold_q <= req[win];
      src_q  <= win;
    end
  end

  fbranch u_cmp (
    .func3 (hold_q.func3),
    .rs1   (hold_q.rs1),
    .rs2   (hold_q.rs2),
    .jump  (bus.out_jump)
  );

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];
  assign bus.out_valid  = (state_q == FULL);
  assign bus.out_src    = src_q;
  assign bus.out_tag    = hold_q.tag;

  ap_rdy_onehot: assert property (@(posedge clk) disable iff (!rstn) !(rdy[0] && rdy[1]));
  ap_rdy_vld:    assert property (@(posedge clk) disable iff (!rstn) (rdy & ~vld) == 2'b00);
  ap_stall_hold: assert property (@(posedge clk) disable iff (!rstn)
                   (state_q == FULL && !bus.out_ready && !flush) |=> ($stable(hold_q) && $stable(src_q)));
endmodule

// File: tb/tb_fbr_arbiter.sv
// Scoreboard bench for fbr_arbiter: accepted requests push their expected
// result, the result channel pops and compares.
module tb_fbr_arbiter;
  localparam logic [2:0] FBEQ = 3'b000;
  localparam logic [2:0] FBNE = 3'b001;
  localparam logic [2:0] FBLT = 3'b100;
  localparam logic [2:0] FBGE = 3'b111;

  typedef struct {
    logic       src;
    logic [4:0] tag;
    logic       jump;
  } exp_t;

  logic clk, rstn, flush;
  logic exp0_j, exp1_j;
  int   checks, errors;
  exp_t sbq [$];

  fbr_arbiter_if #(.TAG_W(5)) bus ();

  fbr_arbiter #(.TAG_W(5), .FIXED_PRIO(1'b0)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic drv0(input logic v, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] t, input logic j);
    bus.req0_valid = v; bus.req0_func3 = f; bus.req0_rs1 = a;
    bus.req0_rs2 = b; bus.req0_tag = t; exp0_j = j;
  endtask

  task automatic drv1(input logic v, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] t, input logic j);
    bus.req1_valid = v; bus.req1_func3 = f; bus.req1_rs1 = a;
    bus.req1_rs2 = b; bus.req1_tag = t; exp1_j = j;
  endtask

  // Result channel pops before this cycle's acceptances push.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn) begin
      if (bus.out_valid && (bus.out_ready || flush)) begin
        if (sbq.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
        else begin
          e = sbq.pop_front();
          if (bus.out_ready) begin
            chk("sb_src",  32'(bus.out_src),  32'(e.src));
            chk("sb_tag",  32'(bus.out_tag),  32'(e.tag));
            chk("sb_jump", 32'(bus.out_jump), 32'(e.jump));
          end
        end
      end
      if (bus.req0_valid && bus.req0_ready) sbq.push_back('{1'b0, bus.req0_tag, exp0_j});
      if (bus.req1_valid && bus.req1_ready) sbq.push_back('{1'b1, bus.req1_tag, exp1_j});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b0; flush = 1'b0; bus.out_ready = 1'b1;
    drv0(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);
    drv1(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_tag",   32'(bus.out_tag),   32'(0));
    chk("rst_src",   32'(bus.out_src),   32'(0));
    cyc();
    rstn = 1'b1;

    // Single port-0 request: +0 == -0.
    drv0(1'b1, FBEQ, 32'h00000000, 32'h80000000, 5'd3, 1'b1);
    neg();
    chk("p0_rdy", 32'({bus.req1_ready, bus.req0_ready}), 32'(2'b01));
    cyc();
    drv0(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);
    neg();
    chk("p0_valid", 32'(bus.out_valid), 32'(1));
    chk("p0_jump",  32'(bus.out_jump),  32'(1));
    chk("p0_src",   32'(bus.out_src),   32'(0));
    chk("p0_tag",   32'(bus.out_tag),   32'(3));
    cyc();

    // NaN operand on port 1, back to back.
    drv1(1'b1, FBLT, 32'h7FC00000, 32'h3F800000, 5'd1, 1'b0);
    neg();
    chk("nan_rdy", 32'(bus.req1_ready), 32'(1));
    cyc();
    drv1(1'b1, FBGE, 32'h7FC00000, 32'h3F800000, 5'd2, 1'b1);
    neg();
    chk("nan_lt", 32'(bus.out_jump), 32'(0));
    cyc();
    drv1(1'b1, FBNE, 32'h7FC00000, 32'h3F800000, 5'd4, 1'b1);
    neg();
    chk("nan_ge", 32'(bus.out_jump), 32'(1));
    cyc();
    drv1(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);
    neg();
    chk("nan_ne", 32'(bus.out_jump), 32'(1));
    cyc();

    // Round-robin with both ports valid.
    drv0(1'b1, FBEQ, 32'h3F800000, 32'h3F800000, 5'd10, 1'b1);
    drv1(1'b1, FBLT, 32'h40000000, 32'h3F800000, 5'd20, 1'b0);
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("rr_rdy", 32'({bus.req1_ready, bus.req0_ready}), (i % 2) ? 32'(2) : 32'(1));
      if (i > 0) begin
        chk("rr_valid", 32'(bus.out_valid), 32'(1));
        chk("rr_src",   32'(bus.out_src),   32'((i - 1) % 2));
      end
      cyc();
    end
    drv0(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);
    drv1(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);
    neg();
    chk("rr_last", 32'({bus.out_valid, bus.out_src}), 32'(2'b11));
    cyc();

    // Backpressure: result held, pending request granted on drain.
    drv0(1'b1, FBLT, 32'hBF800000, 32'h3F800000, 5'd7, 1'b1);
    neg();
    chk("bp_rdy0", 32'(bus.req0_ready), 32'(1));
    cyc();
    drv0(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);
    drv1(1'b1, FBEQ, 32'h3F800000, 32'h3F800000, 5'd8, 1'b1);
    bus.out_ready = 1'b0;
    repeat (3) begin
      neg();
      chk("bp_valid", 32'(bus.out_valid), 32'(1));
      chk("bp_jump",  32'(bus.out_jump),  32'(1));
      chk("bp_tag",   32'(bus.out_tag),   32'(7));
      chk("bp_rdy",   32'({bus.req1_ready, bus.req0_ready}), 32'(0));
      cyc();
    end
    bus.out_ready = 1'b1;
    neg();
    chk("bp_drain_rdy", 32'(bus.req1_ready), 32'(1));
    cyc();
    drv1(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);
    neg();
    chk("bp_next_tag", 32'(bus.out_tag), 32'(8));
    cyc();

    // Flush while FULL with both ports valid.
    drv0(1'b1, FBEQ, 32'h0, 32'h0, 5'd11, 1'b1);
    neg();
    chk("fl_pre_rdy", 32'(bus.req0_ready), 32'(1));
    cyc();
    drv0(1'b1, FBEQ, 32'h0, 32'h0, 5'd12, 1'b1);
    drv1(1'b1, FBNE, 32'h0, 32'h80000000, 5'd21, 1'b0);
    flush = 1'b1; bus.out_ready = 1'b0;
    neg();
    chk("fl_rdy",   32'({bus.req1_ready, bus.req0_ready}), 32'(0));
    chk("fl_shown", 32'(bus.out_valid), 32'(1));
    cyc();
    flush = 1'b0; bus.out_ready = 1'b1;
    neg();
    chk("fl_valid", 32'(bus.out_valid), 32'(0));
    chk("fl_rr",    32'({bus.req1_ready, bus.req0_ready}), 32'(2'b10));
    cyc();
    drv0(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);
    drv1(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);
    neg();
    chk("fl_after", 32'({bus.out_valid, bus.out_src}), 32'(2'b11));
    cyc();

    // Async reset mid-cycle while FULL.
    drv0(1'b1, FBLT, 32'hBF800000, 32'h3F800000, 5'd13, 1'b1);
    bus.out_ready = 1'b0;
    neg();
    chk("ar_rdy", 32'(bus.req0_ready), 32'(1));
    cyc();
    drv0(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);
    neg();
    chk("ar_full", 32'(bus.out_valid), 32'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 32'(0));
    chk("ar_tag",   32'(bus.out_tag),   32'(0));
    chk("ar_src",   32'(bus.out_src),   32'(0));
    sbq.delete();
    cyc();
    rstn = 1'b1; bus.out_ready = 1'b1;
    drv0(1'b1, FBEQ, 32'h00000000, 32'h80000000, 5'd14, 1'b1);
    drv1(1'b1, FBLT, 32'hBF800000, 32'h3F800000, 5'd22, 1'b1);
    neg();
    chk("ar_first", 32'({bus.req1_ready, bus.req0_ready}), 32'(2'b01));
    cyc();
    drv0(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);
    drv1(1'b0, FBEQ, 32'h0, 32'h0, 5'd0, 1'b0);

    for (int k = 0; k < 20 && sbq.size() != 0; k++) cyc();
    chk("sb_drain", 32'(sbq.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
